// File: rtl/task_frame_parser_if.sv
// Byte-stream and payload-beat signals shared by the frame parser and its environment.
// master drives received bytes and observes beats; slave is the parser itself.
interface task_frame_parser_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       o_valid;
    logic       o_first;
    logic       o_last;
    logic [7:0] o_data;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_valid, o_first, o_last, o_data, o_frame_err, o_busy
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_valid, o_first, o_last, o_data, o_frame_err, o_busy
    );
endinterface

// File: rtl/task_frame_parser.sv
// Frame parser: SOF, LEN, payload beats with first/last flags and an idle timeout.
// Define TASK_FRAME_CHECKSUM_EN to expect a trailing XOR checksum byte per frame.
module task_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input logic                 i_clk,
    input logic                 i_rst,
    task_frame_parser_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD
`ifdef TASK_FRAME_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            firstPend_q, firstPend_d;
    logic            valid_q, valid_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic [7:0]      data_q, data_d;
    logic            err_q, err_d;
    logic            timeoutHit;
`ifdef TASK_FRAME_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
    logic [7:0]      hold_q, hold_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            firstPend_q <= 1'b0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
`ifdef TASK_FRAME_CHECKSUM_EN
            xor_q       <= '0;
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            firstPend_q <= firstPend_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            data_q      <= data_d;
            err_q       <= err_d;
`ifdef TASK_FRAME_CHECKSUM_EN
            xor_q       <= xor_d;
            hold_q      <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        firstPend_d = firstPend_q;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        data_d      = '0;
        err_d       = 1'b0;
`ifdef TASK_FRAME_CHECKSUM_EN
        xor_d       = xor_q;
        hold_d      = hold_q;
`endif
        // An arriving byte always beats the timeout in the same cycle.
        timeoutHit = (state_q != IDLE) && !bus.i_rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        if (state_q == IDLE || bus.i_rx_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.i_rx_valid && bus.i_rx_data == SOF_BYTE) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d       = bus.i_rx_data;
                        firstPend_d = 1'b1;
                        state_d     = PAYLOAD;
`ifdef TASK_FRAME_CHECKSUM_EN
                        xor_d       = bus.i_rx_data;
`endif
                    end
                end
            end
            PAYLOAD: begin
                if (bus.i_rx_valid) begin
                    cnt_d = cnt_q - 8'd1;
`ifdef TASK_FRAME_CHECKSUM_EN
                    xor_d = xor_q ^ bus.i_rx_data;
                    if (cnt_q == 8'd1) begin
                        hold_d  = bus.i_rx_data;
                        state_d = CHK;
                    end else begin
                        valid_d     = 1'b1;
                        first_d     = firstPend_q;
                        data_d      = bus.i_rx_data;
                        firstPend_d = 1'b0;
                    end
`else
                    valid_d     = 1'b1;
                    first_d     = firstPend_q;
                    last_d      = (cnt_q == 8'd1);
                    data_d      = bus.i_rx_data;
                    firstPend_d = 1'b0;
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef TASK_FRAME_CHECKSUM_EN
            CHK: begin
                if (bus.i_rx_valid) begin
                    valid_d     = 1'b1;
                    first_d     = firstPend_q;
                    last_d      = 1'b1;
                    data_d      = hold_q;
                    err_d       = (bus.i_rx_data != xor_q);
                    firstPend_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (timeoutHit) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
`ifdef TASK_FRAME_CHECKSUM_EN
            if (state_q == CHK) begin
                valid_d     = 1'b1;
                first_d     = firstPend_q;
                last_d      = 1'b1;
                data_d      = hold_q;
                firstPend_d = 1'b0;
            end
`endif
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_first     = first_q;
    assign bus.o_last      = last_q;
    assign bus.o_data      = data_q;
    assign bus.o_frame_err = err_q;
    assign bus.o_busy      = (state_q != IDLE);

endmodule
